ysyx_23060171_wbu: RTL and testbench

Write-back unit for the multicycle NPC core; the writer side of the decode stage's GPR/CSR write ports. Accepts one completed instruction from the LSU over a valid/ready handshake and selects the GPR and CSR write data. It then drives the register-file write ports for exactly one cycle and signals retirement to the IFU over a second valid/ready handshake. It also keeps a retired-instruction counter.

---
 rtl/ysyx_23060171_pkg.sv | 22 ++
 rtl/ysyx_23060171_wbu_if.sv | 49 ++++
 rtl/ysyx_23060171_wbu_mux.sv | 38 +++
 rtl/ysyx_23060171_wbu.sv | 118 +++++++++++
 tb/tb_ysyx_23060171_wbu.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_23060171_pkg.sv
// Shared NPC constants: write-back data-select encodings and the WBU state enum.
package ysyx_23060171_pkg;

    // GPR write-data select (RegwriteD)
    localparam logic [2:0] WB_ALU = 3'd0;
    localparam logic [2:0] WB_MEM = 3'd1;
    localparam logic [2:0] WB_PC4 = 3'd2;
    localparam logic [2:0] WB_IMM = 3'd3;
    localparam logic [2:0] WB_CSR = 3'd4;

    // CSR write-data select (CSRWriteD)
    localparam logic [1:0] CW_ALU = 2'd0;
    localparam logic [1:0] CW_PC  = 2'd1;

    // Write-back unit states
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWrite = 2'd1,
        StDone  = 2'd2
    } wbu_state_e;

endpackage

// File: rtl/ysyx_23060171_wbu_if.sv
// Write-back bus: LSU-to-WBU instruction handshake, register-file write ports
// and WBU-to-IFU retirement handshake.
interface ysyx_23060171_wbu_if #(
    parameter int unsigned CNT_W = 32
);
    // LSU -> WBU
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      alu_res;
    logic [31:0]      mem_rdata;
    logic [31:0]      crd1;
    logic [31:0]      pc;
    logic [31:0]      pc_plus_4;
    logic [31:0]      immext;
    logic [2:0]       RegwriteD;
    logic [1:0]       CSRWriteD;
    logic             RegwriteE;
    logic             CSRWriteE;
    logic [4:0]       rw;
    logic [11:0]      crw;
    // WBU -> register files
    logic [31:0]      wd;
    logic [31:0]      csr_wd;
    logic [4:0]       rwW;
    logic [11:0]      crwW;
    logic             RegwriteEW;
    logic             CSRWriteEW;
    // WBU <-> IFU
    logic             done_valid;
    logic             done_ready;
    logic [CNT_W-1:0] retired;

    // Surrounding core (LSU, IFU, register files)
    modport master (
        output in_valid, alu_res, mem_rdata, crd1, pc, pc_plus_4, immext,
               RegwriteD, CSRWriteD, RegwriteE, CSRWriteE, rw, crw, done_ready,
        input  in_ready, wd, csr_wd, rwW, crwW, RegwriteEW, CSRWriteEW,
               done_valid, retired
    );

    // Write-back unit
    modport slave (
        input  in_valid, alu_res, mem_rdata, crd1, pc, pc_plus_4, immext,
               RegwriteD, CSRWriteD, RegwriteE, CSRWriteE, rw, crw, done_ready,
        output in_ready, wd, csr_wd, rwW, crwW, RegwriteEW, CSRWriteEW,
               done_valid, retired
    );

endinterface

// File: rtl/ysyx_23060171_wbu_mux.sv
// Combinational GPR and CSR write-data selection.
module ysyx_23060171_wbu_mux
    import ysyx_23060171_pkg::*;
(
    input  logic [2:0]  regwriteD,
    input  logic [1:0]  csrWriteD,
    input  logic [31:0] aluRes,
    input  logic [31:0] memRdata,
    input  logic [31:0] crd1,
    input  logic [31:0] pc,
    input  logic [31:0] pcPlus4,
    input  logic [31:0] immext,
    output logic [31:0] wd,
    output logic [31:0] csrWd
);

    // GPR data: unused encodings write zero
    always_comb begin
        wd = 32'h0;
        case (regwriteD)
            WB_ALU:  wd = aluRes;
            WB_MEM:  wd = memRdata;
            WB_PC4:  wd = pcPlus4;
            WB_IMM:  wd = immext;
            WB_CSR:  wd = crd1;
            default: wd = 32'h0;
        endcase
    end

    // CSR data: only trap entry writes the PC (mepc); everything else takes the ALU result
    always_comb begin
        csrWd = aluRes;
        if (csrWriteD == CW_PC) begin
            csrWd = pc;
        end
    end

endmodule

// File: rtl/ysyx_23060171_wbu.sv
// Write-back unit: latches one completed instruction, pulses the GPR/CSR write
// ports for one cycle, then reports retirement to the IFU.
module ysyx_23060171_wbu
    import ysyx_23060171_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    ysyx_23060171_wbu_if.slave      wbIf
);

    wbu_state_e       stateQ;
    logic             inReadyQ;
    logic             doneValidQ;
    logic             regWeQ;
    logic             csrWeQ;
    logic [CNT_W-1:0] retiredQ;

    logic [31:0]      aluResQ;
    logic [31:0]      memRdataQ;
    logic [31:0]      crd1Q;
    logic [31:0]      pcQ;
    logic [31:0]      pcPlus4Q;
    logic [31:0]      immextQ;
    logic [2:0]       regwriteDQ;
    logic [1:0]       csrWriteDQ;
    logic [4:0]       rwQ;
    logic [11:0]      crwQ;

    // FSM, input latches, registered handshake/strobe outputs and retire counter.
    // The write strobes are computed at acceptance so they are high exactly in WRITE.
    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ     <= StIdle;
            inReadyQ   <= 1'b1;
            doneValidQ <= 1'b0;
            regWeQ     <= 1'b0;
            csrWeQ     <= 1'b0;
            retiredQ   <= '0;
            aluResQ    <= 32'h0;
            memRdataQ  <= 32'h0;
            crd1Q      <= 32'h0;
            pcQ        <= 32'h0;
            pcPlus4Q   <= 32'h0;
            immextQ    <= 32'h0;
            regwriteDQ <= 3'h0;
            csrWriteDQ <= 2'h0;
            rwQ        <= 5'h0;
            crwQ       <= 12'h0;
        end else begin
            case (stateQ)
                StIdle: begin
                    if (wbIf.in_valid) begin
                        aluResQ    <= wbIf.alu_res;
                        memRdataQ  <= wbIf.mem_rdata;
                        crd1Q      <= wbIf.crd1;
                        pcQ        <= wbIf.pc;
                        pcPlus4Q   <= wbIf.pc_plus_4;
                        immextQ    <= wbIf.immext;
                        regwriteDQ <= wbIf.RegwriteD;
                        csrWriteDQ <= wbIf.CSRWriteD;
                        rwQ        <= wbIf.rw;
                        crwQ       <= wbIf.crw;
                        // x0 is hardwired: never strobe a write to it
                        regWeQ     <= wbIf.RegwriteE && (wbIf.rw != 5'd0);
                        csrWeQ     <= wbIf.CSRWriteE;
                        inReadyQ   <= 1'b0;
                        stateQ     <= StWrite;
                    end
                end
                StWrite: begin
                    regWeQ     <= 1'b0;
                    csrWeQ     <= 1'b0;
                    doneValidQ <= 1'b1;
                    stateQ     <= StDone;
                end
                StDone: begin
                    if (wbIf.done_ready) begin
                        doneValidQ <= 1'b0;
                        inReadyQ   <= 1'b1;
                        retiredQ   <= retiredQ + 1'b1;
                        stateQ     <= StIdle;
                    end
                end
                default: begin
                    regWeQ     <= 1'b0;
                    csrWeQ     <= 1'b0;
                    doneValidQ <= 1'b0;
                    inReadyQ   <= 1'b1;
                    stateQ     <= StIdle;
                end
            endcase
        end
    end

    ysyx_23060171_wbu_mux uMux (
        .regwriteD (regwriteDQ),
        .csrWriteD (csrWriteDQ),
        .aluRes    (aluResQ),
        .memRdata  (memRdataQ),
        .crd1      (crd1Q),
        .pc        (pcQ),
        .pcPlus4   (pcPlus4Q),
        .immext    (immextQ),
        .wd        (wbIf.wd),
        .csrWd     (wbIf.csr_wd)
    );

    assign wbIf.rwW        = rwQ;
    assign wbIf.crwW       = crwQ;
    assign wbIf.RegwriteEW = regWeQ;
    assign wbIf.CSRWriteEW = csrWeQ;
    assign wbIf.in_ready   = inReadyQ;
    assign wbIf.done_valid = doneValidQ;
    assign wbIf.retired    = retiredQ;

endmodule

// File: tb/tb_ysyx_23060171_wbu.sv
// Directed bench for the write-back unit.
module tb_ysyx_23060171_wbu;
    import ysyx_23060171_pkg::*;

    logic clk;
    logic rst;
    int   nChecks;
    int   nFails;

    ysyx_23060171_wbu_if #(.CNT_W(32)) wbIf ();

    ysyx_23060171_wbu #(.CNT_W(32)) dut (
        .clk  (clk),
        .rst  (rst),
        .wbIf (wbIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 2ns after it.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic issue();
        wbIf.in_valid = 1'b1;
        tick();
        wbIf.in_valid = 1'b0;
    endtask

    task automatic retire();
        wbIf.done_ready = 1'b1;
        tick();
        wbIf.done_ready = 1'b0;
    endtask

    task automatic setData(input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] c1,
                           input logic [31:0] p, input logic [31:0] p4, input logic [31:0] imm);
        wbIf.alu_res   = alu;
        wbIf.mem_rdata = mem;
        wbIf.crd1      = c1;
        wbIf.pc        = p;
        wbIf.pc_plus_4 = p4;
        wbIf.immext    = imm;
    endtask

    task automatic setCtl(input logic [2:0] rd, input logic [1:0] cd, input logic re,
                          input logic ce, input logic [4:0] r, input logic [11:0] c);
        wbIf.RegwriteD = rd;
        wbIf.CSRWriteD = cd;
        wbIf.RegwriteE = re;
        wbIf.CSRWriteE = ce;
        wbIf.rw        = r;
        wbIf.crw       = c;
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Select table: RegwriteD, CSRWriteD, expected wd, expected csr_wd
    logic [2:0]  selRd  [4] = '{WB_IMM, WB_CSR, 3'd6, WB_MEM};
    logic [1:0]  selCd  [4] = '{2'd2, CW_PC, 2'd3, CW_ALU};
    logic [31:0] expWd  [4] = '{32'h55555555, 32'h66666666, 32'h0, 32'h22222222};
    logic [31:0] expCsr [4] = '{32'h11111111, 32'h33333333, 32'h11111111, 32'h11111111};

    initial begin
        nChecks = 0;
        nFails  = 0;
        rst = 1'b1;
        wbIf.in_valid   = 1'b0;
        wbIf.done_ready = 1'b0;
        setData(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        setCtl(WB_ALU, CW_ALU, 1'b0, 1'b0, 5'd0, 12'h0);
        doReset();

        // Reset state
        checkEq("rst_in_ready", {31'b0, wbIf.in_ready}, 32'd1);
        checkEq("rst_done_valid", {31'b0, wbIf.done_valid}, 32'd0);
        checkEq("rst_regwe", {31'b0, wbIf.RegwriteEW}, 32'd0);
        checkEq("rst_csrwe", {31'b0, wbIf.CSRWriteEW}, 32'd0);
        checkEq("rst_wd", wbIf.wd, 32'h0);
        checkEq("rst_csr_wd", wbIf.csr_wd, 32'h0);
        checkEq("rst_rwW", {27'b0, wbIf.rwW}, 32'd0);
        checkEq("rst_crwW", {20'b0, wbIf.crwW}, 32'd0);
        checkEq("rst_retired", wbIf.retired, 32'd0);

        // done_ready while idle is ignored
        wbIf.done_ready = 1'b1;
        tick();
        tick();
        wbIf.done_ready = 1'b0;
        checkEq("idle_ready_ignored", wbIf.retired, 32'd0);

        // ALU write to x5
        setData(32'h12345678, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        setCtl(WB_ALU, CW_ALU, 1'b1, 1'b0, 5'd5, 12'h0);
        issue();
        checkEq("alu_regwe", {31'b0, wbIf.RegwriteEW}, 32'd1);
        checkEq("alu_wd", wbIf.wd, 32'h12345678);
        checkEq("alu_rwW", {27'b0, wbIf.rwW}, 32'd5);
        checkEq("alu_csrwe", {31'b0, wbIf.CSRWriteEW}, 32'd0);
        checkEq("alu_in_ready", {31'b0, wbIf.in_ready}, 32'd0);
        checkEq("alu_dv_early", {31'b0, wbIf.done_valid}, 32'd0);
        tick();
        checkEq("alu_regwe_off", {31'b0, wbIf.RegwriteEW}, 32'd0);
        checkEq("alu_done_valid", {31'b0, wbIf.done_valid}, 32'd1);
        retire();
        checkEq("alu_retired", wbIf.retired, 32'd1);
        checkEq("alu_back_idle", {31'b0, wbIf.in_ready}, 32'd1);
        checkEq("alu_dv_clear", {31'b0, wbIf.done_valid}, 32'd0);

        // Load to x0: no write strobe, still retires
        setData(32'h0, 32'hFFFFFF80, 32'h0, 32'h0, 32'h0, 32'h0);
        setCtl(WB_MEM, CW_ALU, 1'b1, 1'b0, 5'd0, 12'h0);
        issue();
        checkEq("x0_regwe_w", {31'b0, wbIf.RegwriteEW}, 32'd0);
        checkEq("x0_wd", wbIf.wd, 32'hFFFFFF80);
        tick();
        checkEq("x0_regwe_d", {31'b0, wbIf.RegwriteEW}, 32'd0);
        checkEq("x0_done_valid", {31'b0, wbIf.done_valid}, 32'd1);
        retire();
        checkEq("x0_retired", wbIf.retired, 32'd2);

        // csrrw: GPR and CSR write in the same cycle
        setData(32'h80000000, 32'h0, 32'hAAAA5555, 32'h0, 32'h0, 32'h0);
        setCtl(WB_CSR, CW_ALU, 1'b1, 1'b1, 5'd3, 12'h305);
        issue();
        checkEq("csrrw_csrwe", {31'b0, wbIf.CSRWriteEW}, 32'd1);
        checkEq("csrrw_csr_wd", wbIf.csr_wd, 32'h80000000);
        checkEq("csrrw_crwW", {20'b0, wbIf.crwW}, 32'h305);
        checkEq("csrrw_regwe", {31'b0, wbIf.RegwriteEW}, 32'd1);
        checkEq("csrrw_wd", wbIf.wd, 32'hAAAA5555);
        checkEq("csrrw_rwW", {27'b0, wbIf.rwW}, 32'd3);
        tick();
        checkEq("csrrw_csrwe_off", {31'b0, wbIf.CSRWriteEW}, 32'd0);
        retire();
        checkEq("csrrw_retired", wbIf.retired, 32'd3);

        // ecall: mepc <- pc; link value on the GPR data path without a GPR write
        setData(32'h00000001, 32'h0, 32'h0, 32'h80000010, 32'h80000014, 32'h0);
        setCtl(WB_PC4, CW_PC, 1'b0, 1'b1, 5'd1, 12'h341);
        issue();
        checkEq("ecall_csr_wd", wbIf.csr_wd, 32'h80000010);
        checkEq("ecall_crwW", {20'b0, wbIf.crwW}, 32'h341);
        checkEq("ecall_csrwe", {31'b0, wbIf.CSRWriteEW}, 32'd1);
        checkEq("ecall_regwe", {31'b0, wbIf.RegwriteEW}, 32'd0);
        checkEq("ecall_wd", wbIf.wd, 32'h80000014);
        tick();

        // Backpressure in DONE with new input offered
        setData(32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        setCtl(WB_ALU, CW_ALU, 1'b1, 1'b1, 5'd7, 12'h300);
        wbIf.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checkEq("hold_done_valid", {31'b0, wbIf.done_valid}, 32'd1);
            checkEq("hold_in_ready", {31'b0, wbIf.in_ready}, 32'd0);
            checkEq("hold_regwe", {31'b0, wbIf.RegwriteEW}, 32'd0);
            checkEq("hold_csrwe", {31'b0, wbIf.CSRWriteEW}, 32'd0);
            checkEq("hold_csr_wd", wbIf.csr_wd, 32'h80000010);
            checkEq("hold_crwW", {20'b0, wbIf.crwW}, 32'h341);
            tick();
        end
        wbIf.in_valid = 1'b0;
        checkEq("hold_retired", wbIf.retired, 32'd3);
        retire();
        checkEq("hold_retired_after", wbIf.retired, 32'd4);
        checkEq("hold_no_accept", {31'b0, wbIf.in_ready}, 32'd1);

        // Select table sweep
        setData(32'h11111111, 32'h22222222, 32'h66666666, 32'h33333333, 32'h44444444, 32'h55555555);
        for (int i = 0; i < 4; i++) begin
            setCtl(selRd[i], selCd[i], 1'b1, 1'b1, 5'd9, 12'h340);
            issue();
            checkEq("sel_wd", wbIf.wd, expWd[i]);
            checkEq("sel_csr_wd", wbIf.csr_wd, expCsr[i]);
            tick();
            retire();
        end
        checkEq("sel_retired", wbIf.retired, 32'd8);

        // Reset during WRITE drops the instruction
        doReset();
        setData(32'hCAFEF00D, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        setCtl(WB_ALU, CW_ALU, 1'b1, 1'b1, 5'd4, 12'h300);
        issue();
        checkEq("rw_pre_regwe", {31'b0, wbIf.RegwriteEW}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkEq("rw_regwe", {31'b0, wbIf.RegwriteEW}, 32'd0);
        checkEq("rw_csrwe", {31'b0, wbIf.CSRWriteEW}, 32'd0);
        checkEq("rw_done_valid", {31'b0, wbIf.done_valid}, 32'd0);
        checkEq("rw_retired", wbIf.retired, 32'd0);
        checkEq("rw_in_ready", {31'b0, wbIf.in_ready}, 32'd1);
        checkEq("rw_wd", wbIf.wd, 32'h0);
        tick();
        checkEq("rw_still_idle", {31'b0, wbIf.done_valid}, 32'd0);

        // Reset during DONE with done_ready high: no retirement
        issue();
        tick();
        checkEq("rd_pre_dv", {31'b0, wbIf.done_valid}, 32'd1);
        rst = 1'b1;
        wbIf.done_ready = 1'b1;
        tick();
        rst = 1'b0;
        wbIf.done_ready = 1'b0;
        checkEq("rd_retired", wbIf.retired, 32'd0);
        checkEq("rd_done_valid", {31'b0, wbIf.done_valid}, 32'd0);
        checkEq("rd_in_ready", {31'b0, wbIf.in_ready}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end

endmodule
